// File: rtl/disp_mode_ctrl_if.sv
// Button/timebase inputs and display-control outputs of disp_mode_ctrl.
// The master side drives the buttons and tick; the slave side is the mode sequencer.
interface disp_mode_ctrl_if;
    logic       tick;
    logic       mode_btn;
    logic       adj_btn;
    logic       alarm_active;
    logic [1:0] sel;
    logic       set_time_en;
    logic       set_alarm_en;
    logic       adj_pulse;
    logic       blank;

    modport master (
        output tick, mode_btn, adj_btn, alarm_active,
        input  sel, set_time_en, set_alarm_en, adj_pulse, blank
    );

    modport slave (
        input  tick, mode_btn, adj_btn, alarm_active,
        output sel, set_time_en, set_alarm_en, adj_pulse, blank
    );
endinterface

// File: rtl/disp_mode_ctrl.sv
// Alarm-clock display mode sequencer: show time / set time / set alarm, adjust strobe, timeout.
// Define DISP_BLINK_EN to build the blink flop that drives blank in set modes.
module disp_mode_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_mode_ctrl_if.slave io_if
);

    typedef enum logic [1:0] {
        StShowTime = 2'd0,
        StSetTime  = 2'd1,
        StSetAlarm = 2'd2
    } state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_TICKS - 1);

    state_e     r_state;
    logic       r_mode_q;
    logic       r_adj_q;
    logic [7:0] r_cnt;
    logic       r_adj_pulse;

    logic w_mode_rise;
    logic w_adj_rise;
    logic w_in_set;
    logic w_timeout;

    assign w_mode_rise = io_if.mode_btn & ~r_mode_q;
    assign w_adj_rise  = io_if.adj_btn & ~r_adj_q;
    assign w_in_set    = (r_state == StSetTime) || (r_state == StSetAlarm);
    assign w_timeout   = w_in_set & io_if.tick & (r_cnt == TimeoutLast);

    // Edge flops reset high so a button held through reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StShowTime;
            r_mode_q    <= 1'b1;
            r_adj_q     <= 1'b1;
            r_cnt       <= 8'd0;
            r_adj_pulse <= 1'b0;
        end else begin
            r_mode_q    <= io_if.mode_btn;
            r_adj_q     <= io_if.adj_btn;
            r_adj_pulse <= ~io_if.alarm_active & w_in_set & w_adj_rise & ~w_mode_rise;

            if (io_if.alarm_active) begin
                r_state <= StShowTime;
            end else if (w_mode_rise) begin
                case (r_state)
                    StShowTime: r_state <= StSetTime;
                    StSetTime:  r_state <= StSetAlarm;
                    default:    r_state <= StShowTime;
                endcase
            end else if (w_timeout || !w_in_set) begin
                r_state <= StShowTime;
            end

            if (io_if.alarm_active || !w_in_set || w_mode_rise || w_adj_rise || w_timeout) begin
                r_cnt <= 8'd0;
            end else if (io_if.tick && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign io_if.sel          = r_state;
    assign io_if.set_time_en  = (r_state == StSetTime);
    assign io_if.set_alarm_en = (r_state == StSetAlarm);
    assign io_if.adj_pulse    = r_adj_pulse;

`ifdef DISP_BLINK_EN
    logic r_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= 1'b0;
        end else if (io_if.alarm_active || !w_in_set || w_mode_rise || w_adj_rise
                     || w_timeout) begin
            r_blank <= 1'b0;
        end else if (io_if.tick) begin
            r_blank <= ~r_blank;
        end
    end

    assign io_if.blank = r_blank;
`else
    assign io_if.blank = 1'b0;
`endif

endmodule
